// File: rtl/fht_ctrl_pkg.sv
// Shared types and constants for the fht_but butterfly sequencer.
// Optional feature macro used by the top: FHT_STAGE_PULSE_EN.
package fht_ctrl_pkg;

    localparam int N_POINT_DEF = 256;
    localparam int A_BIT_DEF   = 8;
    localparam int D_BIT_DEF   = 17;
    localparam int W_BIT       = 12;

    // Butterfly read-to-result latency and the X0 lag behind X1/X2.
    localparam int BUT_LAT     = 3;
    localparam int X0_SKEW     = 1;

    localparam int IDX_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Reflected index (h - j) mod h; h is always a power of two.
    function automatic logic [IDX_W-1:0] refl_idx(input logic [IDX_W-1:0] h,
                                                  input logic [IDX_W-1:0] j);
        refl_idx = (h - j) & (h - 16'd1);
    endfunction

endpackage

// File: rtl/fht_but_ctrl_if.sv
// Memory/ROM/butterfly-side bus of the sequencer; master = controller.
interface fht_but_ctrl_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 17
);
    logic             oBANK;
    logic             oRD_EN;
    logic [A_BIT-1:0] oRD_ADDR_0;
    logic [A_BIT-1:0] oRD_ADDR_1;
    logic [A_BIT-1:0] oRD_ADDR_2;
    logic [A_BIT-2:0] oTW_ADDR;
    logic [D_BIT-1:0] iRD_DATA_0;
    logic [D_BIT-1:0] oX_0;
    logic [D_BIT-1:0] iY_0;
    logic [D_BIT-1:0] iY_1;
    logic             oWR_EN;
    logic [A_BIT-1:0] oWR_ADDR_0;
    logic [A_BIT-1:0] oWR_ADDR_1;
    logic [D_BIT-1:0] oWR_DATA_0;
    logic [D_BIT-1:0] oWR_DATA_1;

    modport master (
        output oBANK, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
        output oX_0, oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1,
        input  iRD_DATA_0, iY_0, iY_1
    );

    modport slave (
        input  oBANK, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
        input  oX_0, oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1,
        output iRD_DATA_0, iY_0, iY_1
    );

endinterface

// File: rtl/fht_addr_gen.sv
// Stage/group/index counters and the radix-2 Hartley address and twiddle equations.
module fht_addr_gen
    import fht_ctrl_pkg::*;
#(
    parameter int N_POINT = N_POINT_DEF,
    parameter int A_BIT   = A_BIT_DEF
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic             next_stage_i,
    output logic [A_BIT-1:0] addr_0_o,
    output logic [A_BIT-1:0] addr_1_o,
    output logic [A_BIT-1:0] addr_2_o,
    output logic [A_BIT-2:0] tw_o,
    output logic             last_in_stage_o,
    output logic             last_stage_o
);

    localparam logic [A_BIT-1:0] ONE_A = {{(A_BIT-1){1'b0}}, 1'b1};
    localparam logic [A_BIT-2:0] ONE_G = {{(A_BIT-2){1'b0}}, 1'b1};

    logic [A_BIT-1:0] s_q, s_d;
    logic [A_BIT-2:0] g_q, g_d, j_q, j_d;
    logic [A_BIT-1:0] h_s, base_s, j_ext_s, g_ext_s, g_max_s, shift_s, refl_s;
    logic             last_j_s, last_g_s;

    // Address, twiddle and wrap-flag equations from the current counters.
    always_comb begin
        h_s      = ONE_A << s_q;
        j_ext_s  = {1'b0, j_q};
        g_ext_s  = {1'b0, g_q};
        base_s   = g_ext_s << (s_q + ONE_A);
        g_max_s  = (A_BIT'(N_POINT / 2) >> s_q) - ONE_A;
        shift_s  = A_BIT'(A_BIT - 1) - s_q;
        refl_s   = A_BIT'(refl_idx(IDX_W'(h_s), IDX_W'(j_ext_s)));
        last_j_s = (j_ext_s == (h_s - ONE_A));
        last_g_s = (g_ext_s == g_max_s);
    end

    assign addr_0_o        = base_s + j_ext_s;
    assign addr_1_o        = base_s + h_s + j_ext_s;
    assign addr_2_o        = base_s + h_s + refl_s;
    assign tw_o            = (A_BIT-1)'(j_ext_s << shift_s);
    assign last_in_stage_o = last_j_s && last_g_s;
    assign last_stage_o    = (s_q == A_BIT'(A_BIT - 1));

    // Counter next state: j fastest, g on j wrap, s only between stages.
    always_comb begin
        s_d = s_q;
        g_d = g_q;
        j_d = j_q;
        if (clr_i) begin
            s_d = '0;
            g_d = '0;
            j_d = '0;
        end else if (next_stage_i) begin
            s_d = s_q + ONE_A;
            g_d = '0;
            j_d = '0;
        end else if (adv_i) begin
            if (last_j_s) begin
                j_d = '0;
                if (last_g_s) begin
                    g_d = '0;
                end else begin
                    g_d = g_q + ONE_G;
                end
            end else begin
                j_d = j_q + ONE_G;
            end
        end else begin
            s_d = s_q;
        end
    end

    // Counter registers.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            s_q <= '0;
            g_q <= '0;
            j_q <= '0;
        end else begin
            s_q <= s_d;
            g_q <= g_d;
            j_q <= j_d;
        end
    end

endmodule

// File: rtl/fht_but_ctrl.sv
// Sequencer for one fht_but instance: RUN/DRAIN per stage, X0 alignment, write-back delay line.
// Define FHT_STAGE_PULSE_EN to add the oSTAGE_DONE per-stage pulse output.
module fht_but_ctrl
    import fht_ctrl_pkg::*;
#(
    parameter int N_POINT = N_POINT_DEF,
    parameter int A_BIT   = A_BIT_DEF,
    parameter int D_BIT   = D_BIT_DEF
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iSTART,
    output logic oBUSY,
    output logic oDONE,
`ifdef FHT_STAGE_PULSE_EN
    output logic oSTAGE_DONE,
`endif
    fht_but_ctrl_if.master bus
);

    localparam logic [1:0] DRAIN_LAST = 2'(BUT_LAT - 1);

    state_e                        state_q;
    logic [1:0]                    dcnt_q;
    logic                          busy_q, done_q, rd_en_q, bank_q;
    logic [D_BIT-1:0]              x0_q;
    logic [BUT_LAT-1:0]            v_q;
    logic [BUT_LAT-1:0][A_BIT-1:0] wa0_q, wa1_q;
`ifdef FHT_STAGE_PULSE_EN
    logic                          stage_done_q;
`endif

    logic             clr_s, adv_s, next_stage_s, last_in_stage_s, last_stage_s;
    logic [A_BIT-1:0] addr_0_s, addr_1_s, addr_2_s;
    logic [A_BIT-2:0] tw_s;

    assign clr_s        = (state_q == IDLE) && iSTART;
    assign adv_s        = (state_q == RUN);
    assign next_stage_s = (state_q == DRAIN) && (dcnt_q == DRAIN_LAST) && !last_stage_s;

    fht_addr_gen #(
        .N_POINT (N_POINT),
        .A_BIT   (A_BIT)
    ) u_addr_gen (
        .iCLK            (iCLK),
        .iRESET          (iRESET),
        .clr_i           (clr_s),
        .adv_i           (adv_s),
        .next_stage_i    (next_stage_s),
        .addr_0_o        (addr_0_s),
        .addr_1_o        (addr_1_s),
        .addr_2_o        (addr_2_s),
        .tw_o            (tw_s),
        .last_in_stage_o (last_in_stage_s),
        .last_stage_o    (last_stage_s)
    );

    // Transform FSM with registered status and strobe outputs.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q      <= IDLE;
            dcnt_q       <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            bank_q       <= 1'b0;
`ifdef FHT_STAGE_PULSE_EN
            stage_done_q <= 1'b0;
`endif
        end else begin
            done_q       <= 1'b0;
`ifdef FHT_STAGE_PULSE_EN
            stage_done_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (iSTART) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_in_stage_s) begin
                        state_q <= DRAIN;
                        dcnt_q  <= 2'd0;
                        rd_en_q <= 1'b0;
                    end
                end
                DRAIN: begin
`ifdef FHT_STAGE_PULSE_EN
                    stage_done_q <= (dcnt_q == (DRAIN_LAST - 2'd1));
`endif
                    // Last write of the stage commits in this final cycle, before the bank flips.
                    if (dcnt_q == DRAIN_LAST) begin
                        bank_q <= ~bank_q;
                        if (last_stage_s) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // X0 capture and the valid+address delay line matching the butterfly latency.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            x0_q  <= '0;
            v_q   <= '0;
            wa0_q <= '0;
            wa1_q <= '0;
        end else begin
            v_q   <= {v_q[BUT_LAT-2:0], rd_en_q};
            wa0_q <= {wa0_q[BUT_LAT-2:0], addr_0_s};
            wa1_q <= {wa1_q[BUT_LAT-2:0], addr_1_s};
            if (v_q[X0_SKEW-1]) begin
                x0_q <= bus.iRD_DATA_0;
            end
        end
    end

    assign oBUSY          = busy_q;
    assign oDONE          = done_q;
`ifdef FHT_STAGE_PULSE_EN
    assign oSTAGE_DONE    = stage_done_q;
`endif
    assign bus.oBANK      = bank_q;
    assign bus.oRD_EN     = rd_en_q;
    assign bus.oRD_ADDR_0 = addr_0_s;
    assign bus.oRD_ADDR_1 = addr_1_s;
    assign bus.oRD_ADDR_2 = addr_2_s;
    assign bus.oTW_ADDR   = tw_s;
    assign bus.oX_0       = x0_q;
    assign bus.oWR_EN     = v_q[BUT_LAT-1];
    assign bus.oWR_ADDR_0 = wa0_q[BUT_LAT-1];
    assign bus.oWR_ADDR_1 = wa1_q[BUT_LAT-1];
    assign bus.oWR_DATA_0 = bus.iY_0;
    assign bus.oWR_DATA_1 = bus.iY_1;

endmodule

// File: tb/tb_fht_but_ctrl.sv
// Directed bench for fht_but_ctrl at N_POINT=8 with hand-computed address tables.
module tb_fht_but_ctrl;

    localparam int NP = 8;
    localparam int AB = 3;
    localparam int DB = 17;

    logic iCLK = 1'b0;
    logic iRESET;
    logic iSTART;
    logic oBUSY;
    logic oDONE;
`ifdef FHT_STAGE_PULSE_EN
    logic oSTAGE_DONE;
`endif

    int checks = 0;
    int errors = 0;

    // Issue order for N=8: stage 0, stage 1, stage 2, four butterflies each.
    int ea0[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int ea1[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int ea2[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 7, 6, 5};
    int etw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    fht_but_ctrl_if #(.A_BIT(AB), .D_BIT(DB)) bus ();

    fht_but_ctrl #(
        .N_POINT (NP),
        .A_BIT   (AB),
        .D_BIT   (DB)
    ) dut (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iSTART      (iSTART),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE),
`ifdef FHT_STAGE_PULSE_EN
        .oSTAGE_DONE (oSTAGE_DONE),
`endif
        .bus         (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Cycle c counts from the first RUN cycle; each stage is 4 issues + 3 drain cycles.
    function automatic bit rd_at(int c);
        return (c >= 0) && (c < 21) && ((c % 7) < 4);
    endfunction

    function automatic int k_at(int c);
        return (c / 7) * 4 + (c % 7);
    endfunction

    task automatic test_reset();
        iRESET = 1'b0;
        iSTART = 1'b0;
        bus.iRD_DATA_0 = 17'h0;
        bus.iY_0 = 17'h0;
        bus.iY_1 = 17'h0;
        tick();
        tick();
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", oBUSY); end
        checks++; if (oDONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", oDONE); end
        checks++; if (bus.oRD_EN !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.oRD_EN); end
        checks++; if (bus.oWR_EN !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.oWR_EN); end
        checks++; if (bus.oBANK !== 1'b0) begin errors++; $display("FAIL reset_bank got %b exp 0", bus.oBANK); end
        checks++; if (bus.oX_0 !== 17'h0) begin errors++; $display("FAIL reset_x0 got %h exp 0", bus.oX_0); end
        iRESET = 1'b1;
        tick();
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", oBUSY); end
    endtask

    task automatic test_full_run(input bit hold, input bit b0);
        int pulses;
        pulses = 0;
        iSTART = 1'b1;
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL pre_busy got %b exp 0", oBUSY); end
        tick();
        if (!hold) iSTART = 1'b0;
        for (int c = 0; c <= 21; c++) begin
            int  st, pos, k, kw;
            bit  erd, ewr, ebank;
            logic [DB-1:0] y0, y1;
            st    = c / 7;
            pos   = c % 7;
            erd   = rd_at(c);
            ewr   = (c < 21) && (pos >= 3);
            k     = k_at(c);
            kw    = st * 4 + pos - 3;
            ebank = b0 ^ st[0];
            bus.iRD_DATA_0 = rd_at(c - 1) ? DB'(32'h155 + k_at(c - 1)) : 17'h0;
            y0 = DB'(32'h10000 + c);
            y1 = DB'(32'h0AA00 + c);
            bus.iY_0 = y0;
            bus.iY_1 = y1;
            #1;
            checks++; if (oBUSY !== (c < 21)) begin errors++; $display("FAIL busy c=%0d got %b exp %b", c, oBUSY, (c < 21)); end
            checks++; if (oDONE !== (c == 21)) begin errors++; $display("FAIL done c=%0d got %b exp %b", c, oDONE, (c == 21)); end
            checks++; if (bus.oRD_EN !== erd) begin errors++; $display("FAIL rd_en c=%0d got %b exp %b", c, bus.oRD_EN, erd); end
            checks++; if (bus.oBANK !== ebank) begin errors++; $display("FAIL bank c=%0d got %b exp %b", c, bus.oBANK, ebank); end
            if (erd) begin
                checks++; if (bus.oRD_ADDR_0 !== AB'(ea0[k])) begin errors++; $display("FAIL rd_addr0 c=%0d got %0d exp %0d", c, bus.oRD_ADDR_0, ea0[k]); end
                checks++; if (bus.oRD_ADDR_1 !== AB'(ea1[k])) begin errors++; $display("FAIL rd_addr1 c=%0d got %0d exp %0d", c, bus.oRD_ADDR_1, ea1[k]); end
                checks++; if (bus.oRD_ADDR_2 !== AB'(ea2[k])) begin errors++; $display("FAIL rd_addr2 c=%0d got %0d exp %0d", c, bus.oRD_ADDR_2, ea2[k]); end
                checks++; if (bus.oTW_ADDR !== (AB-1)'(etw[k])) begin errors++; $display("FAIL tw c=%0d got %0d exp %0d", c, bus.oTW_ADDR, etw[k]); end
            end
            checks++; if (bus.oWR_EN !== ewr) begin errors++; $display("FAIL wr_en c=%0d got %b exp %b", c, bus.oWR_EN, ewr); end
            if (ewr) begin
                checks++; if (bus.oWR_ADDR_0 !== AB'(ea0[kw])) begin errors++; $display("FAIL wr_addr0 c=%0d got %0d exp %0d", c, bus.oWR_ADDR_0, ea0[kw]); end
                checks++; if (bus.oWR_ADDR_1 !== AB'(ea1[kw])) begin errors++; $display("FAIL wr_addr1 c=%0d got %0d exp %0d", c, bus.oWR_ADDR_1, ea1[kw]); end
                checks++; if (bus.oWR_DATA_0 !== y0) begin errors++; $display("FAIL wr_data0 c=%0d got %h exp %h", c, bus.oWR_DATA_0, y0); end
                checks++; if (bus.oWR_DATA_1 !== y1) begin errors++; $display("FAIL wr_data1 c=%0d got %h exp %h", c, bus.oWR_DATA_1, y1); end
            end
            if (rd_at(c - 2)) begin
                checks++; if (bus.oX_0 !== DB'(32'h155 + k_at(c - 2))) begin errors++; $display("FAIL x0 c=%0d got %h exp %h", c, bus.oX_0, DB'(32'h155 + k_at(c - 2))); end
            end
`ifdef FHT_STAGE_PULSE_EN
            checks++; if (oSTAGE_DONE !== ((c < 21) && (pos == 6))) begin errors++; $display("FAIL stage_done c=%0d got %b exp %b", c, oSTAGE_DONE, ((c < 21) && (pos == 6))); end
            if (oSTAGE_DONE === 1'b1) pulses++;
`endif
            if (c == 21) iSTART = 1'b0;
            if (c < 21) tick();
        end
        tick();
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL post_busy got %b exp 0", oBUSY); end
        checks++; if (oDONE !== 1'b0) begin errors++; $display("FAIL post_done got %b exp 0", oDONE); end
        checks++; if (bus.oRD_EN !== 1'b0) begin errors++; $display("FAIL post_rd_en got %b exp 0", bus.oRD_EN); end
`ifdef FHT_STAGE_PULSE_EN
        checks++; if (pulses != 3) begin errors++; $display("FAIL stage_pulses got %0d exp 3", pulses); end
`endif
    endtask

    task automatic test_reset_mid();
        bus.iRD_DATA_0 = 17'h1ABCD;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        repeat (9) tick();
        checks++; if (bus.oRD_EN !== 1'b1) begin errors++; $display("FAIL mid_rd_en got %b exp 1", bus.oRD_EN); end
        checks++; if (bus.oX_0 !== 17'h1ABCD) begin errors++; $display("FAIL mid_x0 got %h exp 1abcd", bus.oX_0); end
        iRESET = 1'b0;
        #1;
        checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", oBUSY); end
        checks++; if (bus.oRD_EN !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en got %b exp 0", bus.oRD_EN); end
        checks++; if (bus.oWR_EN !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en got %b exp 0", bus.oWR_EN); end
        checks++; if (bus.oX_0 !== 17'h0) begin errors++; $display("FAIL rst_mid_x0 got %h exp 0", bus.oX_0); end
        checks++; if (bus.oBANK !== 1'b0) begin errors++; $display("FAIL rst_mid_bank got %b exp 0", bus.oBANK); end
        checks++; if (bus.oRD_ADDR_0 !== 3'd0) begin errors++; $display("FAIL rst_mid_addr0 got %0d exp 0", bus.oRD_ADDR_0); end
        tick();
        iRESET = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.oWR_EN !== 1'b0) begin errors++; $display("FAIL trail_wr_en i=%0d got %b exp 0", i, bus.oWR_EN); end
            checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL trail_busy i=%0d got %b exp 0", i, oBUSY); end
        end
    endtask

    initial begin
        test_reset();
        test_full_run(1'b0, 1'b0);
        test_full_run(1'b1, 1'b1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fht_but_ctrl.md
Name: fht_but_ctrl

Overview:
Sequencer that drives the fht_but butterfly from the memory side. It issues operand read addresses and twiddle-ROM addresses, and aligns X0 to the butterfly's internal one-cycle product stage. It captures butterfly results and issues write-backs over one radix-2 Hartley pass of all stages. Sits between the ping-pong sample RAM, the sin/cos ROM and one fht_but instance.

Parameters:
N_POINT, 256, transform length, power of two, minimum 8
A_BIT, 8, log2(N_POINT); RAM address width and stage count
D_BIT, 17, sample width, matches fht_but
W_BIT, 12, twiddle width; only forwarded into the package, no arithmetic here

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous, active-low reset
iSTART  in  1  start one full transform; honoured only in IDLE
oBUSY  out  1  high in RUN/DRAIN
oDONE  out  1  one-cycle pulse at end of transform
oBANK  out  1  read bank select; write bank is ~oBANK
oRD_EN  out  1  read strobe, one butterfly per cycle
oRD_ADDR_0/1/2  out  A_BIT each  addresses of X0, X1, X2 (X2 = reflected X1)
oTW_ADDR  out  A_BIT-1  twiddle ROM address
iRD_DATA_0  in  D_BIT  RAM data for X0, valid 1 cycle after oRD_EN
oX_0  out  D_BIT  X0 to butterfly, registered
iY_0, iY_1  in  D_BIT each  butterfly outputs
oWR_EN  out  1  write strobe for both results
oWR_ADDR_0/1  out  A_BIT each  write addresses of Y0, Y1
oWR_DATA_0/1  out  D_BIT each  iY_0/iY_1 passed through combinationally

Behaviour:
- Reset (iRESET low, asynchronous, any time including mid-transform): state IDLE, counters 0, oBANK 0, all strobes 0, oX_0 0, write-pipeline valid bits cleared. No pending write survives.
- States:
  - IDLE --iSTART--> RUN (stage s=0, group g=0, index j=0).
  - RUN issues one butterfly per cycle. After the last butterfly of a stage (N_POINT/2 issues) --> DRAIN.
  - DRAIN lasts exactly 3 cycles. Then toggle oBANK; s<A_BIT-1 --> RUN with s+1; else --> DONE.
  - DONE asserts oDONE for 1 cycle --> IDLE.
  - iSTART outside IDLE is ignored.
- Address rule for stage s (h = 2^s, base = g*2h, j in 0..h-1):
  - ADDR_0 = base+j
  - ADDR_1 = base+h+j
  - ADDR_2 = base+h+((h-j) mod h)
  - TW = j << (A_BIT-1-s)
  - j wraps to 0 at h-1 and increments g; g wraps at N_POINT/(2h)-1.
- Timing, issue at cycle t:
  - RAM and ROM data valid at t+1; X1, X2 and sin/cos are wired externally to the butterfly.
  - oX_0 <= iRD_DATA_0 at end of t+1, so X0 reaches the butterfly one cycle later than X1/X2.
  - Butterfly output valid at t+3. oWR_EN=1 at t+3 with addresses ADDR_0/ADDR_1 of cycle t, delayed through a 3-deep valid+address pipeline.
- DRAIN guarantees the last write of stage s commits before the first read of stage s+1. Reads always come from oBANK and writes go to ~oBANK, so reflected reads never see partial results.
- Throughput: A_BIT*(N_POINT/2+3) cycles from first RUN cycle to DONE.

Optional Feature:
FHT_STAGE_PULSE_EN
- With: extra output oSTAGE_DONE (1 bit) pulses for one cycle on the final DRAIN cycle of every stage, including the last (coincides with the bank toggle).
- Without: port absent, no logic.

Decomposition:
- Package fht_ctrl_pkg: state enum {IDLE, RUN, DRAIN, DONE}, BUT_LAT=3, X0_SKEW=1, and a function computing the reflected index (h-j) mod h.
- One natural sub-module, fht_addr_gen: s/g/j counters plus the address and twiddle equations, with last_in_stage and last_stage flags. The top holds the FSM, the X0 register and the write delay line.

Test Plan:
- N=8, pulse iSTART: stage 0 issues (0,1,1,tw0),(2,3,3,tw0),(4,5,5,tw0),(6,7,7,tw0); oBUSY rises next cycle.
- N=8, stage 2, j=1: ADDR=(1,5,7), TW=1; j=0 gives (0,4,4), TW=0.
- Latency: read at t with iRD_DATA_0=0x155 at t+1 -> oX_0=0x155 at t+2. Butterfly model output at t+3 -> oWR_EN=1 with ADDR_0/1 of t.
- N=8 full run: oDONE exactly 21 cycles after first RUN cycle; oBANK toggles 3 times (ends 1); no write overlaps the next stage's first read.
- iSTART held high during RUN: no restart, sequence unchanged. Reset mid-stage 1: all outputs 0 next cycle, no trailing oWR_EN.
- FHT_STAGE_PULSE_EN defined, N=8: oSTAGE_DONE pulses 3 times, 7 cycles apart.
